// File: rtl/dualmem_pkg.sv
// Shared types and helpers for the asymmetric dual-port buffer.
//   state_e      : controller states (INIT clears the array, RUN serves requests)
//   calc_aw_b    : wide-port address width from the wide depth
//   calc_aw_a    : narrow-port address width from the wide depth and the ratio
//   lane_expand  : moves a narrow value (data or byte enables) into its lane
//                  of a wide word; callers keep only the low bits they need
package dualmem_pkg;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Upper bound on the wide word width handled by lane_expand.
    localparam int LANE_MAX_W = 1024;

    function automatic int calc_aw_b(input int wide_depth);
        return $clog2(wide_depth);
    endfunction

    function automatic int calc_aw_a(input int wide_depth, input int ratio);
        return $clog2(wide_depth) + $clog2(ratio);
    endfunction

    // Little-endian lane placement: lane k lands at bit k*lane_w.
    function automatic logic [LANE_MAX_W-1:0] lane_expand(
        input logic [LANE_MAX_W-1:0] narrow,
        input int                    lane,
        input int                    lane_w
    );
        return narrow << (lane * lane_w);
    endfunction

endpackage

// File: rtl/dualmem_bank.sv
// Storage array for the dual-port buffer: DEPTH x WIDE_W, two byte-enabled
// write ports and two registered read-first read ports.
//   clk                    : clock
//   rst                    : synchronous active-high reset (read registers only)
//   a_we_i/a_be_i/a_addr_i/a_wdata_i : port A write (already widened to a wide word)
//   a_re_i, a_rdata_o      : port A read request and registered read data
//   b_*                    : same roles for port B; B wins on a common byte
module dualmem_bank #(
    parameter int WIDE_W = 64,
    parameter int DEPTH  = 2048,
    parameter int AW     = 11
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                a_we_i,
    input  logic                a_re_i,
    input  logic [WIDE_W/8-1:0] a_be_i,
    input  logic [AW-1:0]       a_addr_i,
    input  logic [WIDE_W-1:0]   a_wdata_i,
    output logic [WIDE_W-1:0]   a_rdata_o,
    input  logic                b_we_i,
    input  logic                b_re_i,
    input  logic [WIDE_W/8-1:0] b_be_i,
    input  logic [AW-1:0]       b_addr_i,
    input  logic [WIDE_W-1:0]   b_wdata_i,
    output logic [WIDE_W-1:0]   b_rdata_o
);

    logic [WIDE_W-1:0] mem_q [DEPTH];
    logic [WIDE_W-1:0] a_rdata_q;
    logic [WIDE_W-1:0] b_rdata_q;

    // Byte-enabled writes; B is assigned last so it wins on a shared byte.
    always_ff @(posedge clk) begin
        for (int i = 0; i < WIDE_W/8; i++) begin
            if (a_we_i && a_be_i[i]) begin
                mem_q[a_addr_i][i*8 +: 8] <= a_wdata_i[i*8 +: 8];
            end
            if (b_we_i && b_be_i[i]) begin
                mem_q[b_addr_i][i*8 +: 8] <= b_wdata_i[i*8 +: 8];
            end
        end
    end

    // Registered reads sample the array before this edge's writes land (read-first).
    always_ff @(posedge clk) begin
        if (rst) begin
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            if (a_re_i) begin
                a_rdata_q <= mem_q[a_addr_i];
            end
            if (b_re_i) begin
                b_rdata_q <= mem_q[b_addr_i];
            end
        end
    end

    assign a_rdata_o = a_rdata_q;
    assign b_rdata_o = b_rdata_q;

endmodule

// File: rtl/dualmem_widen_ctl.sv
// Asymmetric dual-port buffer controller: narrow port A (NARROW_W) and wide
// port B (NARROW_W*RATIO) sharing one array.
//   clk, rst        : single clock, synchronous active-high reset
//   a_valid/a_ready : port A request handshake (ready only after the clear)
//   a_we/a_be/a_addr/a_wdata : port A write controls and narrow word address
//   a_rvalid/a_rdata: port A read response, one cycle after the request
//   b_*             : same roles for the wide port
//   init_busy       : post-reset zero-fill in progress
//   coll            : one-cycle pulse after a same-word write/write byte overlap
module dualmem_widen_ctl
    import dualmem_pkg::*;
#(
    parameter int NARROW_W   = 16,
    parameter int RATIO      = 4,
    parameter int WIDE_DEPTH = 2048,
    parameter int ZERO_INIT  = 1,
    // Derived widths; leave at their defaults.
    parameter int WIDE_W     = NARROW_W * RATIO,
    parameter int AW_B       = calc_aw_b(WIDE_DEPTH),
    parameter int AW_A       = calc_aw_a(WIDE_DEPTH, RATIO)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic                  a_we,
    input  logic [NARROW_W/8-1:0] a_be,
    input  logic [AW_A-1:0]       a_addr,
    input  logic [NARROW_W-1:0]   a_wdata,
    output logic                  a_rvalid,
    output logic [NARROW_W-1:0]   a_rdata,
    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic                  b_we,
    input  logic [WIDE_W/8-1:0]   b_be,
    input  logic [AW_B-1:0]       b_addr,
    input  logic [WIDE_W-1:0]     b_wdata,
    output logic                  b_rvalid,
    output logic [WIDE_W-1:0]     b_rdata,
    output logic                  init_busy,
    output logic                  coll
);

    localparam int LB   = $clog2(RATIO);
    localparam int NB_A = NARROW_W / 8;
    localparam int NB_B = WIDE_W / 8;

    state_e            state_q, state_d;
    logic [AW_B-1:0]   cnt_q, cnt_d;
    logic              ready_q;
    logic              a_rvalid_q, b_rvalid_q, coll_q;
    logic [LB-1:0]     a_lane_q;

    logic              a_fire_s, b_fire_s;
    logic [LB-1:0]     a_lane_s;
    logic [AW_B-1:0]   a_word_s;
    logic [LANE_MAX_W-1:0] a_wdata_x_s, a_be_x_s;
    logic [WIDE_W-1:0] a_wide_wdata_s;
    logic [NB_B-1:0]   a_wide_be_s;
    logic              unused_lane_hi_s;

    logic              bk_b_we_s, bk_b_re_s;
    logic [NB_B-1:0]   bk_b_be_s;
    logic [AW_B-1:0]   bk_b_addr_s;
    logic [WIDE_W-1:0] bk_b_wdata_s;
    logic [WIDE_W-1:0] bk_a_rdata_s, bk_b_rdata_s;

    // Reset itself blocks firing so nothing reaches the array while rst is high.
    assign a_fire_s = a_valid && ready_q && !rst;
    assign b_fire_s = b_valid && ready_q && !rst;

    assign a_lane_s = a_addr[LB-1:0];
    assign a_word_s = a_addr[AW_A-1:LB];

    assign a_wdata_x_s = lane_expand({{(LANE_MAX_W-NARROW_W){1'b0}}, a_wdata},
                                     int'(a_lane_s), NARROW_W);
    assign a_be_x_s    = lane_expand({{(LANE_MAX_W-NB_A){1'b0}}, a_be},
                                     int'(a_lane_s), NB_A);
    assign a_wide_wdata_s = a_wdata_x_s[WIDE_W-1:0];
    assign a_wide_be_s    = a_be_x_s[NB_B-1:0];
    // Bits above the wide word are always zero after the shift.
    assign unused_lane_hi_s = ^{a_wdata_x_s[LANE_MAX_W-1:WIDE_W], a_be_x_s[LANE_MAX_W-1:NB_B]};

    // Clear sequencer: one wide word per cycle, RUN after the last word.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_INIT: begin
                cnt_d = cnt_q + AW_B'(1);
                if (cnt_q == AW_B'(WIDE_DEPTH - 1)) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_INIT;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_INIT;
                cnt_d   = '0;
            end
        endcase
    end

    // Port B of the bank carries the zero-fill during INIT.
    always_comb begin
        bk_b_we_s    = 1'b0;
        bk_b_re_s    = 1'b0;
        bk_b_be_s    = '0;
        bk_b_addr_s  = '0;
        bk_b_wdata_s = '0;
        if (state_q == ST_INIT) begin
            bk_b_we_s   = 1'b1;
            bk_b_be_s   = '1;
            bk_b_addr_s = cnt_q;
        end else begin
            bk_b_we_s    = b_fire_s && b_we;
            bk_b_re_s    = b_fire_s && !b_we;
            bk_b_be_s    = b_be;
            bk_b_addr_s  = b_addr;
            bk_b_wdata_s = b_wdata;
        end
    end

    // Controller state, handshake, read-valid pipeline and collision flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= (ZERO_INIT != 0) ? ST_INIT : ST_RUN;
            cnt_q      <= '0;
            ready_q    <= 1'b0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            coll_q     <= 1'b0;
            a_lane_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ready_q    <= (state_d == ST_RUN);
            a_rvalid_q <= a_fire_s && !a_we;
            b_rvalid_q <= b_fire_s && !b_we;
            coll_q     <= a_fire_s && a_we && b_fire_s && b_we &&
                          (a_word_s == b_addr) && (|(a_wide_be_s & b_be));
            if (a_fire_s && !a_we) begin
                a_lane_q <= a_lane_s;
            end
        end
    end

    dualmem_bank #(
        .WIDE_W (WIDE_W),
        .DEPTH  (WIDE_DEPTH),
        .AW     (AW_B)
    ) u_bank (
        .clk       (clk),
        .rst       (rst),
        .a_we_i    (a_fire_s && a_we),
        .a_re_i    (a_fire_s && !a_we),
        .a_be_i    (a_wide_be_s),
        .a_addr_i  (a_word_s),
        .a_wdata_i (a_wide_wdata_s),
        .a_rdata_o (bk_a_rdata_s),
        .b_we_i    (bk_b_we_s),
        .b_re_i    (bk_b_re_s),
        .b_be_i    (bk_b_be_s),
        .b_addr_i  (bk_b_addr_s),
        .b_wdata_i (bk_b_wdata_s),
        .b_rdata_o (bk_b_rdata_s)
    );

    assign a_ready   = ready_q;
    assign b_ready   = ready_q;
    assign init_busy = (state_q == ST_INIT);
    assign a_rvalid  = a_rvalid_q;
    assign b_rvalid  = b_rvalid_q;
    // The lane register only moves on a read, so the narrow data holds with the wide word.
    assign a_rdata   = bk_a_rdata_s[a_lane_q*NARROW_W +: NARROW_W];
    assign b_rdata   = bk_b_rdata_s;
    assign coll      = coll_q;

endmodule

// File: tb/tb_dualmem_widen_ctl.sv
module tb_dualmem_widen_ctl;

    localparam int D   = 2048;
    localparam int AWB = 11;
    localparam int AWA = 13;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid, a_ready, a_we, a_rvalid;
    logic [1:0]  a_be;
    logic [AWA-1:0] a_addr;
    logic [15:0] a_wdata, a_rdata;
    logic        b_valid, b_ready, b_we, b_rvalid;
    logic [7:0]  b_be;
    logic [AWB-1:0] b_addr;
    logic [63:0] b_wdata, b_rdata;
    logic        init_busy, coll;

    always #5 clk = ~clk;

    dualmem_widen_ctl dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_be(a_be),
        .a_addr(a_addr), .a_wdata(a_wdata), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we), .b_be(b_be),
        .b_addr(b_addr), .b_wdata(b_wdata), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .init_busy(init_busy), .coll(coll)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: byte-addressed memory plus expected outputs.
    logic [7:0]  mem_b [D*8];
    int          init_left = 0;
    logic        e_arv = 1'b0, e_brv = 1'b0, e_coll = 1'b0;
    logic [15:0] e_ard = 16'h0;
    logic [63:0] e_brd = 64'h0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_edge();
        int ab, bb, off;
        if (rst) begin
            init_left = D;
            e_arv = 1'b0; e_brv = 1'b0; e_coll = 1'b0;
            e_ard = 16'h0; e_brd = 64'h0;
        end else if (init_left > 0) begin
            for (int j = 0; j < 8; j++) mem_b[(D - init_left)*8 + j] = 8'h00;
            init_left--;
            e_arv = 1'b0; e_brv = 1'b0; e_coll = 1'b0;
        end else begin
            ab = int'(a_addr) * 2;
            bb = int'(b_addr) * 8;
            e_arv = a_valid && !a_we;
            e_brv = b_valid && !b_we;
            if (e_arv) e_ard = {mem_b[ab+1], mem_b[ab]};
            if (e_brv) for (int j = 0; j < 8; j++) e_brd[j*8 +: 8] = mem_b[bb+j];
            e_coll = 1'b0;
            if (a_valid && a_we && b_valid && b_we) begin
                for (int j = 0; j < 2; j++) begin
                    off = ab + j - bb;
                    if (a_be[j] && off >= 0 && off < 8 && b_be[off]) e_coll = 1'b1;
                end
            end
            if (a_valid && a_we)
                for (int j = 0; j < 2; j++) if (a_be[j]) mem_b[ab+j] = a_wdata[j*8 +: 8];
            if (b_valid && b_we)
                for (int j = 0; j < 8; j++) if (b_be[j]) mem_b[bb+j] = b_wdata[j*8 +: 8];
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_val("a_ready",   64'(a_ready),   64'(init_left == 0));
        check_val("b_ready",   64'(b_ready),   64'(init_left == 0));
        check_val("init_busy", 64'(init_busy), 64'(init_left > 0));
        check_val("a_rvalid",  64'(a_rvalid),  64'(e_arv));
        check_val("b_rvalid",  64'(b_rvalid),  64'(e_brv));
        check_val("a_rdata",   64'(a_rdata),   64'(e_ard));
        check_val("b_rdata",   b_rdata,        e_brd);
        check_val("coll",      64'(coll),      64'(e_coll));
    endtask

    task automatic idle();
        a_valid = 1'b0; b_valid = 1'b0;
    endtask

    task automatic a_req(input logic we, input logic [AWA-1:0] addr, input logic [15:0] d, input logic [1:0] be);
        a_valid = 1'b1; a_we = we; a_addr = addr; a_wdata = d; a_be = be;
    endtask

    task automatic b_req(input logic we, input logic [AWB-1:0] addr, input logic [63:0] d, input logic [7:0] be);
        b_valid = 1'b1; b_we = we; b_addr = addr; b_wdata = d; b_be = be;
    endtask

    task automatic run_init(input string tag);
        int n;
        n = 0;
        for (int i = 0; i < D + 50 && init_busy; i++) begin
            a_valid = 1'($urandom_range(0, 1)); a_we = 1'($urandom_range(0, 1));
            a_addr = AWA'(20 + $urandom_range(0, 3)); a_wdata = 16'($urandom); a_be = 2'b11;
            b_valid = 1'($urandom_range(0, 1)); b_we = 1'($urandom_range(0, 1));
            b_addr = AWB'(5); b_wdata = {$urandom, $urandom}; b_be = 8'hFF;
            step();
            n++;
        end
        idle();
        check_val(tag, 64'(n), 64'(D));
    endtask

    initial begin
        rst = 1'b1;
        a_valid = 1'b0; a_we = 1'b0; a_be = 2'b00; a_addr = '0; a_wdata = 16'h0;
        b_valid = 1'b0; b_we = 1'b0; b_be = 8'h00; b_addr = '0; b_wdata = 64'h0;
        step();
        check_val("rst_busy", 64'(init_busy), 64'd1);
        step();
        rst = 1'b0;
        run_init("init_len");
        check_val("ready_after_init", 64'({a_ready, b_ready}), 64'd3);

        // Last word reads back zero; rvalid is a single-cycle pulse.
        b_req(1'b0, AWB'(11'h7FF), 64'h0, 8'h00);
        step();
        check_val("b_rd_7ff_valid", 64'(b_rvalid), 64'd1);
        check_val("b_rd_7ff_data", b_rdata, 64'h0);
        idle();
        step();
        check_val("b_rvalid_pulse", 64'(b_rvalid), 64'd0);

        // Wide write, narrow lane reads back-to-back.
        b_req(1'b1, AWB'(5), 64'h0807_0605_0403_0201, 8'hFF);
        step();
        idle();
        a_req(1'b0, AWA'(20), 16'h0, 2'b00); step(); check_val("a_rd20", 64'(a_rdata), 64'h0201);
        a_req(1'b0, AWA'(21), 16'h0, 2'b00); step(); check_val("a_rd21", 64'(a_rdata), 64'h0403);
        a_req(1'b0, AWA'(22), 16'h0, 2'b00); step(); check_val("a_rd22", 64'(a_rdata), 64'h0605);
        a_req(1'b0, AWA'(23), 16'h0, 2'b00); step(); check_val("a_rd23", 64'(a_rdata), 64'h0807);

        // Narrow partial-byte write seen from the wide side.
        a_req(1'b1, AWA'(22), 16'hBEEF, 2'b10); step();
        idle();
        b_req(1'b0, AWB'(5), 64'h0, 8'h00); step();
        check_val("b_rd5_merge", b_rdata, 64'h0807_BE05_0403_0201);
        idle(); step();

        // Write/write collision: B wins on common bytes.
        a_req(1'b1, AWA'(0), 16'h1111, 2'b11);
        b_req(1'b1, AWB'(0), 64'h2222_3333_4444_5555, 8'h03);
        step();
        check_val("coll_pulse", 64'(coll), 64'd1);
        idle();
        b_req(1'b0, AWB'(0), 64'h0, 8'h00); step();
        check_val("coll_b_wins", b_rdata, 64'h0000_0000_0000_5555);
        check_val("coll_clear", 64'(coll), 64'd0);
        idle();

        // Read-first across ports.
        a_req(1'b0, AWA'(0), 16'h0, 2'b00);
        b_req(1'b1, AWB'(0), 64'h0123_4567_89AB_CAFE, 8'hFF);
        step();
        check_val("read_first_old", 64'(a_rdata), 64'h5555);
        idle();
        a_req(1'b0, AWA'(0), 16'h0, 2'b00); step();
        check_val("reread_new", 64'(a_rdata), 64'hCAFE);

        // Reset with a read in flight.
        a_req(1'b0, AWA'(21), 16'h0, 2'b00); step();
        rst = 1'b1;
        a_req(1'b1, AWA'(20), 16'hDEAD, 2'b11);
        step();
        check_val("rst_drop_rvalid", 64'(a_rvalid), 64'd0);
        check_val("rst_init_busy", 64'(init_busy), 64'd1);
        rst = 1'b0;
        run_init("reinit_len");
        b_req(1'b0, AWB'(5), 64'h0, 8'h00); step();
        check_val("reinit_zero", b_rdata, 64'h0);
        idle();

        // Randomised traffic concentrated on a few words for frequent overlap.
        for (int i = 0; i < 3000; i++) begin
            a_valid = 1'($urandom_range(0, 1)); a_we = 1'($urandom_range(0, 1));
            a_be = 2'($urandom); a_wdata = 16'($urandom);
            b_valid = 1'($urandom_range(0, 1)); b_we = 1'($urandom_range(0, 1));
            b_be = 8'($urandom); b_wdata = {$urandom, $urandom};
            if ($urandom_range(0, 7) == 0) begin
                a_addr = AWA'($urandom); b_addr = AWB'($urandom);
            end else begin
                a_addr = AWA'($urandom_range(0, 31)); b_addr = AWB'($urandom_range(0, 7));
            end
            step();
        end
        idle();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
